// File: rtl/rggen_indirect_array_window.sv
// rtl/rggen_indirect_array_window.sv - indirect INDEX/DATA register window onto an internal array
//
// Purpose:
//   Two bus-visible registers front a DEPTH x DATA_WIDTH storage array.
//   Software writes INDEX (index field plus auto_inc in the MSB), then reads
//   or writes DATA, which is steered to array[index]. With auto_inc set, the
//   index advances by one (mod 2**INDEX_WIDTH) after every DATA access.
//   A separate hardware read port gives user logic registered access to any
//   entry.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   i_valid           bus request valid, held until o_ready
//   i_address         request byte address
//   i_write           1 = write, 0 = read
//   i_write_data      write data
//   i_strobe          byte enables for writes
//   o_ready           one-cycle completion pulse
//   o_read_data       read data (0 for writes), valid with o_ready
//   o_error           out-of-range DATA access, valid with o_ready
//   o_hit             combinational address decode of the request
//   i_hw_index        hardware read index
//   o_hw_data         registered array[i_hw_index]; 0 when the index is past DEPTH
module rggen_indirect_array_window #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] INDEX_ADDRESS = 'h0,
  parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS  = 'h4,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DEPTH         = 16,
  parameter int                       INDEX_WIDTH   = 4,
  parameter logic [DATA_WIDTH-1:0]    INITIAL_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic [ADDRESS_WIDTH-1:0]   i_address,
  input  logic                       i_write,
  input  logic [DATA_WIDTH-1:0]      i_write_data,
  input  logic [DATA_WIDTH/8-1:0]    i_strobe,
  output logic                       o_ready,
  output logic [DATA_WIDTH-1:0]      o_read_data,
  output logic                       o_error,
  output logic                       o_hit,
  input  logic [INDEX_WIDTH-1:0]     i_hw_index,
  output logic [DATA_WIDTH-1:0]      o_hw_data
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, INDEX_ACC, DATA_RD, DATA_WR, RESP} state_e;

  state_e                  r_state;
  state_e                  w_next_state;

  logic                    w_is_index_addr;
  logic                    w_hit;
  logic                    w_in_range;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic [DATA_WIDTH-1:0]   w_index_reg;
  logic [DATA_WIDTH-1:0]   w_resp_data;
  logic                    w_resp_error;

  logic                    r_is_index;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STROBE_WIDTH-1:0] r_strobe;
  logic [INDEX_WIDTH-1:0]  r_index;
  logic                    r_auto_inc;
  logic                    r_rd_phase;
  logic [DATA_WIDTH-1:0]   r_array_rd;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic                    r_error;
  logic [DATA_WIDTH-1:0]   r_hw_data;

  assign w_is_index_addr = (i_address == INDEX_ADDRESS);
  assign w_hit           = i_valid && (w_is_index_addr || (i_address == DATA_ADDRESS));
  assign w_in_range      = (32'(r_index) < 32'(DEPTH));

  assign o_hit       = w_hit;
  assign o_ready     = r_ready;
  assign o_read_data = r_read_data;
  assign o_error     = r_error;
  assign o_hw_data   = r_hw_data;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      w_mask[8*i +: 8] = {8{r_strobe[i]}};
    end
  end

  // Software view of INDEX: unused bits read as zero.
  always_comb begin
    w_index_reg                  = '0;
    w_index_reg[INDEX_WIDTH-1:0] = r_index;
    w_index_reg[DATA_WIDTH-1]    = r_auto_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Response data/error are only produced on the transition into RESP, so
  // the output registers naturally return to zero in every other cycle.
  always_comb begin
    w_next_state = r_state;
    w_resp_data  = '0;
    w_resp_error = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          if (w_is_index_addr) begin
            w_next_state = INDEX_ACC;
          end else if (i_write) begin
            w_next_state = DATA_WR;
          end else begin
            w_next_state = DATA_RD;
          end
        end
      end
      INDEX_ACC: begin
        w_next_state = RESP;
        if (!r_write) begin
          w_resp_data = w_index_reg;
        end
      end
      DATA_RD: begin
        // Phase 0 issues the array read, phase 1 has its result.
        if (r_rd_phase) begin
          w_next_state = RESP;
          w_resp_error = !w_in_range;
          if (w_in_range) begin
            w_resp_data = r_array_rd;
          end
        end
      end
      DATA_WR: begin
        w_next_state = RESP;
        w_resp_error = !w_in_range;
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_index  <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_strobe    <= '0;
      r_rd_phase  <= 1'b0;
      r_array_rd  <= '0;
      r_ready     <= 1'b0;
      r_read_data <= '0;
      r_error     <= 1'b0;
    end else begin
      // Request fields are frozen once the FSM leaves IDLE.
      if ((r_state == IDLE) && w_hit) begin
        r_is_index <= w_is_index_addr;
        r_write    <= i_write;
        r_wdata    <= i_write_data;
        r_strobe   <= i_strobe;
      end
      r_rd_phase <= (r_state == DATA_RD) && !r_rd_phase;
      if ((r_state == DATA_RD) && !r_rd_phase && w_in_range) begin
        r_array_rd <= r_mem[r_index];
      end
      r_ready     <= (w_next_state == RESP);
      r_read_data <= w_resp_data;
      r_error     <= w_resp_error;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index    <= '0;
      r_auto_inc <= 1'b0;
    end else if ((r_state == INDEX_ACC) && r_write) begin
      r_index    <= (r_index & ~w_mask[INDEX_WIDTH-1:0]) |
                    (r_wdata[INDEX_WIDTH-1:0] & w_mask[INDEX_WIDTH-1:0]);
      r_auto_inc <= r_strobe[STROBE_WIDTH-1] ? r_wdata[DATA_WIDTH-1] : r_auto_inc;
    end else if ((r_state == RESP) && !r_is_index && r_auto_inc) begin
      // Wraps at 2**INDEX_WIDTH, deliberately not at DEPTH.
      r_index <= r_index + INDEX_WIDTH'(1);
    end
  end

  // The hardware port samples the array before a same-cycle bus write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INITIAL_VALUE;
      end
      r_hw_data <= INITIAL_VALUE;
    end else begin
      if ((r_state == DATA_WR) && w_in_range) begin
        r_mem[r_index] <= (r_mem[r_index] & ~w_mask) | (r_wdata & w_mask);
      end
      r_hw_data <= (32'(i_hw_index) < 32'(DEPTH)) ? r_mem[i_hw_index] : '0;
    end
  end

endmodule

// File: tb/tb_rggen_indirect_array_window.sv
// tb/tb_rggen_indirect_array_window.sv - bench for rggen_indirect_array_window (DEPTH 16 and 12)
module tb_rggen_indirect_array_window;

  localparam logic [15:0] IDX_A  = 16'h0;
  localparam logic [15:0] DAT_A  = 16'h4;
  localparam logic [31:0] INIT12 = 32'h5A5A_0F0F;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [15:0] i_address;
  logic        i_write;
  logic [31:0] i_write_data;
  logic [3:0]  i_strobe;
  logic [3:0]  i_hw_index;

  logic        a_ready, b_ready;
  logic [31:0] a_rdata, b_rdata;
  logic        a_error, b_error;
  logic        a_hit, b_hit;
  logic [31:0] a_hw, b_hw;

  rggen_indirect_array_window u_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_address(i_address), .i_write(i_write),
    .i_write_data(i_write_data), .i_strobe(i_strobe), .o_ready(a_ready), .o_read_data(a_rdata),
    .o_error(a_error), .o_hit(a_hit), .i_hw_index(i_hw_index), .o_hw_data(a_hw)
  );

  rggen_indirect_array_window #(.DEPTH(12), .INITIAL_VALUE(INIT12)) u_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_address(i_address), .i_write(i_write),
    .i_write_data(i_write_data), .i_strobe(i_strobe), .o_ready(b_ready), .o_read_data(b_rdata),
    .o_error(b_error), .o_hit(b_hit), .i_hw_index(i_hw_index), .o_hw_data(b_hw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: software-visible state of both instances.
  int          m_index;
  logic        m_auto;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [12];
  logic [31:0] last_a, last_b;
  logic [31:0] hw_a_at_ready, hw_b_at_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] index_value();
    return (m_auto ? 32'h8000_0000 : 32'h0) | 32'(m_index);
  endfunction

  task automatic model_reset();
    m_index = 0;
    m_auto  = 1'b0;
    for (int i = 0; i < 16; i++) mem_a[i] = '0;
    for (int i = 0; i < 12; i++) mem_b[i] = INIT12;
  endtask

  task automatic access(input string tag, input logic [15:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] ea, eb, v;
    logic        era, erb;
    int          lat, n;
    era = 1'b0;
    erb = 1'b0;
    ea  = '0;
    eb  = '0;
    if (addr == IDX_A) begin
      lat = 2;
      if (wr) begin
        v       = merge(index_value(), wd, st);
        m_index = int'(v[3:0]);
        m_auto  = v[31];
      end else begin
        ea = index_value();
        eb = ea;
      end
    end else begin
      lat = wr ? 2 : 3;
      erb = (m_index >= 12);
      if (wr) begin
        mem_a[m_index] = merge(mem_a[m_index], wd, st);
        if (!erb) mem_b[m_index] = merge(mem_b[m_index], wd, st);
      end else begin
        ea = mem_a[m_index];
        eb = erb ? 32'h0 : mem_b[m_index];
      end
      if (m_auto) m_index = (m_index + 1) % 16;
    end

    @(negedge clk);
    i_valid      = 1'b1;
    i_address    = addr;
    i_write      = wr;
    i_write_data = wd;
    i_strobe     = st;
    #1;
    check({tag, " hit_a"}, 32'(a_hit), 32'd1);
    check({tag, " hit_b"}, 32'(b_hit), 32'd1);
    n = 0;
    while (n < 8 && !(a_ready || b_ready)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " ready_a"}, 32'(a_ready), 32'd1);
    check({tag, " ready_b"}, 32'(b_ready), 32'd1);
    check({tag, " rdata_a"}, a_rdata, ea);
    check({tag, " error_a"}, 32'(a_error), 32'(era));
    check({tag, " rdata_b"}, b_rdata, eb);
    check({tag, " error_b"}, 32'(b_error), 32'(erb));
    last_a        = a_rdata;
    last_b        = b_rdata;
    hw_a_at_ready = a_hw;
    hw_b_at_ready = b_hw;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " pulse_a"}, 32'(a_ready), 32'd0);
    check({tag, " pulse_b"}, 32'(b_ready), 32'd0);
  endtask

  task automatic hw_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      i_hw_index = 4'(i);
      @(posedge clk);
      #1;
      check($sformatf("%s hw_a[%0d]", tag, i), a_hw, mem_a[i]);
      if (i < 12) check($sformatf("%s hw_b[%0d]", tag, i), b_hw, mem_b[i]);
    end
  endtask

  task automatic hw_peek(input int idx, output logic [31:0] va);
    i_hw_index = 4'(idx);
    @(posedge clk);
    #1;
    va = a_hw;
  endtask

  initial begin
    logic [31:0] v;
    rst          = 1'b1;
    i_valid      = 1'b0;
    i_address    = '0;
    i_write      = 1'b0;
    i_write_data = '0;
    i_strobe     = '0;
    i_hw_index   = '0;
    model_reset();
    #1;
    check("reset ready_a", 32'(a_ready), 32'd0);
    check("reset ready_b", 32'(b_ready), 32'd0);
    check("reset rdata_a", a_rdata, 32'h0);
    check("reset error_b", 32'(b_error), 32'd0);
    check("reset hw_a", a_hw, 32'h0);
    check("reset hw_b", b_hw, INIT12);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    access("rd_index0", IDX_A, 1'b0, '0, 4'h0);
    check("rd_index0 const", last_a, 32'h0);
    access("rd_data0", DAT_A, 1'b0, '0, 4'h0);
    check("rd_data0 init_b", last_b, INIT12);

    access("wr_index5", IDX_A, 1'b1, 32'h5, 4'hF);
    access("wr_strobe", DAT_A, 1'b1, 32'hA5A5_1234, 4'b0011);
    access("rd_strobe", DAT_A, 1'b0, '0, 4'h0);
    check("rd_strobe const", last_a, 32'h0000_1234);
    hw_peek(5, v);
    check("hw5 const", v, 32'h0000_1234);

    // Bus write and hardware read of the same entry in the same cycle.
    i_hw_index = 4'd5;
    @(posedge clk);
    v = mem_a[5];
    access("same_cycle", DAT_A, 1'b1, 32'hDEAD_BEEF, 4'hF);
    check("same_cycle old_a", hw_a_at_ready, v);
    check("same_cycle new_a", a_hw, mem_a[5]);
    check("same_cycle new_b", b_hw, mem_b[5]);

    access("wr_index_auto", IDX_A, 1'b1, 32'h8000_000E, 4'hF);
    for (int k = 1; k <= 4; k++) access($sformatf("burst%0d", k), DAT_A, 1'b1, 32'(k), 4'hF);
    access("rd_index_wrap", IDX_A, 1'b0, '0, 4'h0);
    check("rd_index_wrap const", last_a, 32'h8000_0002);
    hw_peek(14, v); check("wrap e14", v, 32'd1);
    hw_peek(15, v); check("wrap e15", v, 32'd2);
    hw_peek(0, v);  check("wrap e0", v, 32'd3);
    hw_peek(1, v);  check("wrap e1", v, 32'd4);

    access("wr_index13", IDX_A, 1'b1, 32'hD, 4'hF);
    access("oor_wr", DAT_A, 1'b1, 32'h1357_9BDF, 4'hF);
    check("oor_wr error_b const", 32'(b_error), 32'd0);
    access("oor_rd", DAT_A, 1'b0, '0, 4'h0);
    check("oor_rd data_b const", last_b, 32'h0);
    hw_sweep("after_oor");

    // Request not addressed to this block.
    @(negedge clk);
    i_valid   = 1'b1;
    i_address = 16'h8;
    i_write   = 1'b1;
    #1;
    check("miss hit_a", 32'(a_hit), 32'd0);
    check("miss hit_b", 32'(b_hit), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("miss ready_a", 32'(a_ready), 32'd0);
    end
    i_valid   = 1'b0;
    i_address = DAT_A;
    #1;
    check("novalid hit_a", 32'(a_hit), 32'd0);

    for (int k = 0; k < 40; k++) begin
      access($sformatf("rnd%0d", k), ($urandom_range(0, 1) == 1) ? DAT_A : IDX_A,
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end
    hw_sweep("after_rnd");

    // Make sure there is something non-reset to lose.
    access("pre_rst_idx", IDX_A, 1'b1, 32'h8000_0003, 4'hF);
    access("pre_rst_wr", DAT_A, 1'b1, 32'hCAFE_F00D, 4'hF);

    // Reset while a DATA read is in flight.
    @(negedge clk);
    i_valid   = 1'b1;
    i_address = DAT_A;
    i_write   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort ready_a", 32'(a_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort hold ready_a", 32'(a_ready), 32'd0);
      check("abort hold ready_b", 32'(b_ready), 32'd0);
    end
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("post_rst ready_a", 32'(a_ready), 32'd0);
    access("post_rst_idx", IDX_A, 1'b0, '0, 4'h0);
    check("post_rst_idx const", last_a, 32'h0);
    hw_sweep("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
